// File: rtl/uart_rx_cmd_ctrl.sv
// Command controller behind the UART receiver: parses write/read/config frames,
// drives register-file strobes, returns read data to the transmitter and owns RX config.
module uart_rx_cmd_ctrl #(
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [7:0]           RX_P_DATA,
    input  logic                 RX_D_VLD,
    input  logic                 RX_PAR_ERR,
    input  logic                 RX_FRM_ERR,
    input  logic [7:0]           RF_RD_DATA,
    input  logic                 RF_RD_DATA_VLD,
    input  logic                 TX_BUSY,
    output logic [ADDR_W-1:0]    RF_ADDR,
    output logic [7:0]           RF_WR_DATA,
    output logic                 RF_WR_EN,
    output logic                 RF_RD_EN,
    output logic [7:0]           TX_P_DATA,
    output logic                 TX_D_VLD,
    output logic                 PAR_EN,
    output logic                 PAR_TYP,
    output logic [3:0]           PRESCALE,
    output logic                 BUSY,
    output logic                 ERR_PULSE,
    output logic [ERR_CNT_W-1:0] ERR_CNT
);

    localparam int              TMO_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_RD_ADDR,
        S_WR_DATA,
        S_CFG_DATA,
        S_RD_WAIT,
        S_TX_WAIT
    } state_t;

    state_t           state, next_state;
    logic [TMO_W-1:0] tmo_cnt;

    logic rx_event, rx_bad, addr_ok, cfg_ok;
    logic err_det, ld_addr, ld_wdata, ld_txd, ld_cfg, wr_go, rd_go, tx_go;

    assign rx_bad   = RX_PAR_ERR | RX_FRM_ERR;
    assign rx_event = RX_D_VLD | rx_bad;
    assign addr_ok  = (RX_P_DATA >> ADDR_W) == 8'd0;
    assign cfg_ok   = RX_P_DATA[5:2] >= 4'd4;

    // Transmit request is issued in the same cycle the transmitter reports idle.
    assign TX_D_VLD = tx_go;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        err_det    = 1'b0;
        ld_addr    = 1'b0;
        ld_wdata   = 1'b0;
        ld_txd     = 1'b0;
        ld_cfg     = 1'b0;
        wr_go      = 1'b0;
        rd_go      = 1'b0;
        tx_go      = 1'b0;
        if (rx_bad) begin
            err_det    = 1'b1;
            next_state = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (RX_D_VLD) begin
                        unique case (RX_P_DATA)
                            8'hAA:   next_state = S_WR_ADDR;
                            8'hBB:   next_state = S_RD_ADDR;
                            8'hCC:   next_state = S_CFG_DATA;
                            default: err_det    = 1'b1;
                        endcase
                    end
                end
                S_WR_ADDR, S_RD_ADDR: begin
                    if (RX_D_VLD) begin
                        if (addr_ok) begin
                            ld_addr    = 1'b1;
                            rd_go      = (state == S_RD_ADDR);
                            next_state = (state == S_RD_ADDR) ? S_RD_WAIT : S_WR_DATA;
                        end else begin
                            err_det    = 1'b1;
                            next_state = S_IDLE;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (RX_D_VLD) begin
                        ld_wdata   = 1'b1;
                        wr_go      = 1'b1;
                        next_state = S_IDLE;
                    end
                end
                S_CFG_DATA: begin
                    if (RX_D_VLD) begin
                        ld_cfg     = cfg_ok;
                        err_det    = !cfg_ok;
                        next_state = S_IDLE;
                    end
                end
                S_RD_WAIT: begin
                    err_det = RX_D_VLD;
                    if (RF_RD_DATA_VLD) begin
                        ld_txd     = 1'b1;
                        next_state = S_TX_WAIT;
                    end
                end
                S_TX_WAIT: begin
                    err_det = RX_D_VLD;
                    if (!TX_BUSY) begin
                        tx_go      = 1'b1;
                        next_state = S_IDLE;
                    end
                end
                default: next_state = S_IDLE;
            endcase
            // Progress made this cycle (state change) takes priority over the timeout.
            if (state != S_IDLE && !rx_event && next_state == state && tmo_cnt == TMO_LAST) begin
                err_det    = 1'b1;
                next_state = S_IDLE;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tmo_cnt    <= '0;
            RF_ADDR    <= '0;
            RF_WR_DATA <= '0;
            RF_WR_EN   <= 1'b0;
            RF_RD_EN   <= 1'b0;
            TX_P_DATA  <= '0;
            PAR_EN     <= 1'b1;
            PAR_TYP    <= 1'b0;
            PRESCALE   <= 4'd8;
            BUSY       <= 1'b0;
            ERR_PULSE  <= 1'b0;
            ERR_CNT    <= '0;
        end else begin
            if (state == S_IDLE || rx_event || next_state != state) tmo_cnt <= '0;
            else                                                    tmo_cnt <= tmo_cnt + 1'b1;
            if (ld_addr)  RF_ADDR    <= RX_P_DATA[ADDR_W-1:0];
            if (ld_wdata) RF_WR_DATA <= RX_P_DATA;
            if (ld_txd)   TX_P_DATA  <= RF_RD_DATA;
            if (ld_cfg) begin
                PAR_EN   <= RX_P_DATA[0];
                PAR_TYP  <= RX_P_DATA[1];
                PRESCALE <= RX_P_DATA[5:2];
            end
            RF_WR_EN  <= wr_go;
            RF_RD_EN  <= rd_go;
            BUSY      <= (next_state != S_IDLE);
            ERR_PULSE <= err_det;
            if (err_det && ERR_CNT != '1) ERR_CNT <= ERR_CNT + 1'b1;
        end
    end

endmodule
